// File: rtl/uo_change_logger_pkg.sv
// Shared types and frame constants for the uo_out change logger.
package uo_change_logger_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uo_log_fifo.sv
// Small power-of-two FIFO with show-ahead read; push while full is accepted only alongside a pop.
module uo_log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uo_change_logger.sv
// Logs every change of an upstream uo_out byte into a FIFO and streams the
// logged bytes out as 8N1 UART frames; drops are flagged and counted.
module uo_change_logger
  import uo_change_logger_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] uo_in,
  input  logic       capture_en,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    sample_q;
  logic [7:0]    last_q;
  logic          push;
  logic          push_ok;
  logic          drop;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] occ_next;
  logic [7:0]    rd_data;
  tx_state_t     state_q;
  tx_state_t     state_d;
  logic [7:0]    baud_q;
  logic [3:0]    bit_q;
  logic [7:0]    shift_q;
  logic          baud_last;
  logic          busy_q;
  logic          overflow_q;
  logic [7:0]    drop_q;

  // Stage p0/p1: input sampling and change detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q <= '0;
      last_q   <= '0;
    end else begin
      sample_q <= uo_in;
      last_q   <= sample_q;
    end
  end

  assign push    = capture_en && (sample_q != last_q);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  uo_log_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (sample_q),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end

  // Stage p2: serial transmitter
  assign baud_last = (baud_q == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!empty) state_d = START;
      START: if (baud_last) state_d = DATA;
      DATA:  if (baud_last && bit_q == 4'(DATA_BITS)) state_d = STOP;
      STOP:  if (baud_last && bit_q == 4'(FRAME_BITS - 1)) state_d = empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx  = 1'b1;
    pop = 1'b0;
    case (state_q)
      IDLE:  pop = !empty;
      START: tx  = 1'b0;
      DATA:  tx  = shift_q[0];
      STOP:  pop = baud_last && !empty;
      default: tx = 1'b1;
    endcase
  end

  // bit_q indexes the frame: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_q <= '0;
      bit_q  <= '0;
    end else if (pop || state_q == IDLE) begin
      baud_q <= '0;
      bit_q  <= '0;
    end else if (baud_last) begin
      baud_q <= '0;
      bit_q  <= bit_q + 1'b1;
    end else begin
      baud_q <= baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                                shift_q <= rd_data;
    else if (state_q == DATA && baud_last)  shift_q <= shift_q >> 1;
  end

  // busy is registered from next-cycle state and occupancy so it never glitches
  always_comb begin
    occ_next = count + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= (state_d != IDLE) || (occ_next != '0);
  end

  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: doc/uo_change_logger.md
UO_CHANGE_LOGGER -- requirements
Module: uo_change_logger

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 uo_in  input  8  byte driven by the upstream tile's uo_out.
REQ-006 capture_en  input  1  high = log changes of uo_in.
REQ-007 tx  output  1  UART-style serial line, idle high.
REQ-008 busy  output  1  high while the FIFO is non-empty or a frame is in flight.
REQ-009 overflow  output  1  sticky flag: a change was dropped.
REQ-010 drop_count  output  8  saturating count of dropped changes.

Function
REQ-011 uo_in SHALL be registered into sample_q every cycle; sample_q SHALL be registered into last_q every cycle.
REQ-012 Change detect: push sample_q into the FIFO at an edge where capture_en=1 and sample_q != last_q.
REQ-013 capture_en=0 SHALL suppress pushes only; sample_q and last_q keep tracking, so re-enabling does not log stale history.
REQ-014 Latency, transmitter idle and FIFO empty: if uo_in changes before edge E0, push occurs at E1, pop at E2, and tx goes low (start bit) from E2.
REQ-015 Push when full and no pop that cycle: drop the byte, set overflow, increment drop_count (saturating at 255).
REQ-016 Push and pop at the same edge while full: accept the push, no drop, occupancy unchanged.
REQ-017 FIFO SHALL preserve order; pointers SHALL wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
REQ-018 TX FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1; if FIFO non-empty, pop into shift_q and enter START.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-021 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then enter STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles; on its last cycle, if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-023 One frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-024 busy = (state != IDLE) or (occupancy != 0), registered-equivalent and glitch-free.
REQ-025 overflow and drop_count SHALL clear only on reset.

Reset
REQ-026 At rst_n=0, the following values SHALL take effect at the next edge: tx=1, busy=0, overflow=0, drop_count=0, state=IDLE, FIFO empty, bit/baud counters=0, sample_q=0, last_q=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (tx=1 from that edge) and discard FIFO contents.
REQ-028 The first nonzero uo_in after reset with capture_en=1 SHALL be logged, because last_q resets to 0.

Structure
REQ-029 A shared package SHALL hold the tx_state_t enum (IDLE, START, DATA, STOP) and the constants FRAME_BITS=10 and DATA_BITS=8.
REQ-030 The FIFO SHALL be a sub-module, uo_log_fifo (params WIDTH=8, DEPTH), with push/pop/full/empty/count ports and a single-cycle push-pop.
REQ-031 The change detector, counters and TX FSM SHALL live in the top level; no other sub-modules.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-032 Reset, then uo_in=0xA5 with capture_en=1 -> tx low from E2; serial bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high; busy drops after 40 cycles.
REQ-033 uo_in steps 0x01,0x02,0x03,0x04,0x05,0x06, one per cycle -> frames 0x01..0x05 sent back-to-back with no gap; 0x06 dropped; overflow=1; drop_count=1.
REQ-034 capture_en=0, uo_in 0x00->0x33, then capture_en=1 with uo_in held -> no frame; later change to 0x34 -> exactly one frame 0x34.
REQ-035 Full FIFO plus a new change at the STOP-to-START pop edge -> no drop; overflow stays 0.
REQ-036 Assert rst_n=0 mid-DATA with 3 queued entries -> tx=1 and busy=0 at the next edge; no further frames after release with uo_in held at 0.
REQ-037 Force 300 drops -> drop_count=255 (saturated); overflow=1.
